// File: rtl/sram_like_pkg.sv
// Shared definitions for the sram_like slave: access-size encodings, the
// response-queue entry layout and the byte-lane write-enable helper.
// The optional response delay is enabled by defining SRAM_LIKE_DELAY_EN.
package sram_like_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef struct packed {
        logic        filled;
        logic        wr;
        logic [31:0] data;
    } resp_entry_t;

    // Byte-lane enables for a write of the given size at the given byte offset.
    // Size 2'b11 is treated like a full word.
    function automatic logic [3:0] size_to_wen(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] wen;
        case (size)
            SIZE_BYTE: wen = 4'b0001 << off;
            SIZE_HALF: wen = off[1] ? 4'b1100 : 4'b0011;
            default:   wen = 4'b1111;
        endcase
        return wen;
    endfunction

endpackage

// File: rtl/sram_like_resp_fifo.sv
// Ordered response queue. Entries are allocated at acceptance, filled one
// cycle later with the SRAM read data (or zero for writes), and popped in
// allocation order. Pop clears the fill flag so a stale entry never looks
// ready once the queue wraps back to it.
module sram_like_resp_fifo
    import sram_like_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alloc,
    input  logic          alloc_wr,
    input  logic          fill,
    input  logic [PW-1:0] fill_idx,
    input  logic [31:0]   fill_data,
    input  logic          pop,
    output logic [CW-1:0] count,
    output logic [PW-1:0] wr_idx,
    output logic [PW-1:0] rd_idx,
    output logic          head_filled,
    output logic [31:0]   head_data
);

    resp_entry_t   entries [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    // Pointer, occupancy and entry-state update.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].filled <= 1'b0;
            end
        end else begin
            if (alloc) begin
                entries[wr_ptr].filled <= 1'b0;
                entries[wr_ptr].wr     <= alloc_wr;
                wr_ptr                 <= wr_ptr + PW'(1);
            end
            if (fill) begin
                entries[fill_idx].filled <= 1'b1;
                entries[fill_idx].data   <= fill_data;
            end
            if (pop) begin
                entries[rd_ptr].filled <= 1'b0;
                rd_ptr                 <= rd_ptr + PW'(1);
            end
            case ({alloc, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign count       = cnt;
    assign wr_idx      = wr_ptr;
    assign rd_idx      = rd_ptr;
    assign head_filled = entries[rd_ptr].filled;
    assign head_data   = entries[rd_ptr].wr ? 32'h0 : entries[rd_ptr].data;

endmodule

// File: rtl/sram_like_slave.sv
// sram_like slave bridging an initiator to a synchronous SRAM with one-cycle
// read latency. Up to DEPTH requests may be outstanding; responses return in
// acceptance order. Defining SRAM_LIKE_DELAY_EN holds each ready response
// DELAY extra cycles; otherwise a response is given the cycle after acceptance.
module sram_like_slave
    import sram_like_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int DELAY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        ram_en,
    output logic [3:0]  ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic          rst_q;
    logic          accept;
    logic          fill_pend;
    logic          fill_wr;
    logic [PW-1:0] fill_idx;
    logic [31:0]   fill_data;
    logic [CW-1:0] count;
    logic [PW-1:0] wr_idx;
    logic [PW-1:0] rd_idx;
    logic          head_filled;
    logic [31:0]   head_data;
    logic          head_ready;
    logic [31:0]   head_data_eff;
    logic          delay_ok;
    logic          pop;

    // Remember reset for one cycle so acceptance stays blocked right after it.
    always_ff @(posedge clk) begin
        rst_q <= rst;
    end

    // Full check uses the pre-pop count: no same-cycle bypass of a freeing slot.
    assign accept       = data_req && !rst && !rst_q && (count < CW'(DEPTH));
    assign data_addr_ok = accept;
    assign ram_en       = accept;
    assign ram_addr     = {data_addr[31:2], 2'b00};
    assign ram_wdata    = data_wdata;
    assign ram_wen      = (accept && data_wr) ? size_to_wen(data_size, data_addr[1:0]) : 4'b0000;

    // Track the entry whose SRAM data arrives next cycle; reset drops it.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_pend <= 1'b0;
            fill_wr   <= 1'b0;
            fill_idx  <= '0;
        end else begin
            fill_pend <= accept;
            fill_wr   <= data_wr;
            fill_idx  <= wr_idx;
        end
    end

    assign fill_data = fill_wr ? 32'h0 : ram_rdata;

    // Head is ready either from its stored copy or from the data arriving now.
    assign head_ready    = head_filled || (fill_pend && (fill_idx == rd_idx));
    assign head_data_eff = head_filled ? head_data : fill_data;

`ifdef SRAM_LIKE_DELAY_EN
    localparam int DW = (DELAY < 1) ? 1 : $clog2(DELAY + 1);

    logic          dly_armed;
    logic [DW-1:0] dly_cnt;
    logic [DW-1:0] dly_rem;

    // Cycles still to wait: full DELAY on the first ready cycle, then counts down.
    assign dly_rem  = dly_armed ? dly_cnt : DW'(DELAY);
    assign delay_ok = (dly_rem == '0);

    // Delay counter: armed when the head becomes ready, released on pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            dly_armed <= 1'b0;
            dly_cnt   <= '0;
        end else if (pop) begin
            dly_armed <= 1'b0;
        end else if (head_ready) begin
            dly_armed <= 1'b1;
            dly_cnt   <= dly_rem - DW'(1);
        end
    end
`else
    assign delay_ok = 1'b1;
`endif

    assign pop          = head_ready && delay_ok && !rst;
    assign data_data_ok = pop;
    assign data_rdata   = pop ? head_data_eff : 32'h0;

    sram_like_resp_fifo #(
        .DEPTH (DEPTH)
    ) u_resp_fifo (
        .clk         (clk),
        .rst         (rst),
        .alloc       (accept),
        .alloc_wr    (data_wr),
        .fill        (fill_pend),
        .fill_idx    (fill_idx),
        .fill_data   (fill_data),
        .pop         (pop),
        .count       (count),
        .wr_idx      (wr_idx),
        .rd_idx      (rd_idx),
        .head_filled (head_filled),
        .head_data   (head_data)
    );

endmodule

// File: tb/tb_sram_like_slave.sv
// Randomized scoreboard bench for sram_like_slave with a small SRAM model.
module tb_sram_like_slave;

    localparam int DEPTH = 2;
`ifdef SRAM_LIKE_DELAY_EN
    localparam int DLY = 3;
`else
    localparam int DLY = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] sram_mem [64];
    logic [31:0] ref_mem  [64];

    sram_like_slave #(.DEPTH(DEPTH), .DELAY(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .ram_en       (ram_en),
        .ram_wen      (ram_wen),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous SRAM: byte-lane writes, read data one cycle after ram_en.
    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_wen[b]) sram_mem[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
            ram_rdata <= sram_mem[ram_addr[7:2]];
        end
    end

    function automatic logic [3:0] exp_wen(input logic [1:0] sz, input logic [1:0] off);
        if (sz == 2'd0) return 4'b0001 << off;
        if (sz == 2'd1) return off[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compare DUT responses against the queue of expected answers.
    initial begin
        logic        rst_prev;
        logic        exp_aok;
        logic        exp_ok;
        logic        popped;
        logic [3:0]  wen;
        logic [31:0] rd;
        int          start;
        rst_prev = 1'b1;
        forever begin
            @(negedge clk);
            exp_aok = data_req && !rst && !rst_prev && (q.size() < DEPTH);
            exp_ok  = !rst && (q.size() > 0) && (q[0].cyc == cyc);
            popped  = 1'b0;
            chk("addr_ok", {31'b0, data_addr_ok}, {31'b0, exp_aok});
            chk("ram_en", {31'b0, ram_en}, {31'b0, exp_aok});
            chk("data_ok", {31'b0, data_data_ok}, {31'b0, exp_ok});
            if (exp_ok && data_data_ok) begin
                chk("rdata", data_rdata, q[0].data);
                void'(q.pop_front());
                popped = 1'b1;
            end else if (!data_data_ok) begin
                chk("rdata_idle", data_rdata, 32'h0);
            end
            if (!popped && q.size() > 0 && q[0].cyc <= cyc) void'(q.pop_front());
            if (exp_aok && data_addr_ok) begin
                wen = data_wr ? exp_wen(data_size, data_addr[1:0]) : 4'b0000;
                chk("ram_addr", ram_addr, {data_addr[31:2], 2'b00});
                chk("ram_wen", {28'b0, ram_wen}, {28'b0, wen});
                chk("ram_wdata", ram_wdata, data_wdata);
                rd = data_wr ? 32'h0 : ref_mem[data_addr[7:2]];
                for (int b = 0; b < 4; b++) begin
                    if (wen[b]) ref_mem[data_addr[7:2]][8*b +: 8] = data_wdata[8*b +: 8];
                end
                start = cyc + 1;
                if (q.size() > 0 && q[$].cyc + 1 > start) start = q[$].cyc + 1;
                q.push_back('{data: rd, cyc: start + DLY});
            end
            if (rst) q.delete();
            rst_prev = rst;
        end
    end

    // Stimulus: randomized requests with two mid-run resets, then drain.
    initial begin
        for (int i = 0; i < 64; i++) begin
            sram_mem[i] = 32'h1000_0001 * (i + 1);
            ref_mem[i]  = 32'h1000_0001 * (i + 1);
        end
        rst        = 1'b1;
        data_req   = 1'b1;
        data_wr    = 1'b0;
        data_size  = 2'd2;
        data_addr  = 32'h0;
        data_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            rst        = (i == 800) || (i == 1900);
            data_req   = ($urandom_range(3) != 0);
            data_wr    = ($urandom_range(2) == 0);
            data_size  = 2'($urandom_range(3));
            data_addr  = 32'($urandom_range(255));
            data_wdata = $urandom;
        end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        data_req = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        #1;
        chk("drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sram_like_slave.md
SRAM_LIKE_SLAVE -- requirements
Module: sram_like_slave

Interface
REQ-001 SHALL have parameter DEPTH, default 2, max outstanding accepted-but-unanswered requests (power of two, 2..8).
REQ-002 SHALL have parameter DELAY, default 3, extra wait cycles before data_ok (used only under SRAM_LIKE_DELAY_EN).
REQ-003 SHALL have port clk  input  1  single clock, all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports data_req in 1, data_wr in 1, data_size in 2, data_addr in 32, data_wdata in 32: sram_like request from initiator.
REQ-006 SHALL have ports data_addr_ok out 1, data_data_ok out 1, data_rdata out 32: sram_like responses.
REQ-007 SHALL have ports ram_en out 1, ram_wen out 4, ram_addr out 32, ram_wdata out 32, ram_rdata in 32: synchronous SRAM, read data valid one cycle after ram_en.

Function
REQ-008 SHALL assert data_addr_ok combinationally iff data_req=1, rst=0 and outstanding count < DEPTH; a request is accepted in a cycle with data_req=1 and data_addr_ok=1.
REQ-009 SHALL drive ram_en=data_addr_ok, ram_addr={data_addr[31:2],2'b00}, ram_wdata=data_wdata unchanged (byte lanes pre-placed by initiator).
REQ-010 SHALL drive ram_wen=0 for reads; for writes: size 0 -> 4'b0001<<addr[1:0]; size 1 -> addr[1]?4'b1100:4'b0011; size 2 or 3 -> 4'b1111.
REQ-011 SHALL allocate one response-queue entry per acceptance, recording wr; for reads capture ram_rdata into that entry exactly one cycle after acceptance; writes are filled at acceptance+1 with rdata=0.
REQ-012 SHALL answer strictly in acceptance order; data_data_ok=1 for one cycle per entry when head entry is filled (and delay satisfied, REQ-019); entry popped that cycle.
REQ-013 SHALL drive data_rdata = head entry data when data_data_ok=1, else 32'b0.
REQ-014 SHALL give minimum latency acceptance at cycle T -> data_data_ok at T+1 (macro off); back-to-back acceptances yield back-to-back data_ok.
REQ-015 SHALL, when accept and pop coincide, keep count unchanged; full is evaluated on pre-pop count (no same-cycle bypass), so at count=DEPTH data_addr_ok=0 even while data_ok=1.
REQ-016 SHALL not require data_ok back-pressure; initiator always consumes data_ok.
REQ-017 SHALL use wrapping pointers of $clog2(DEPTH) bits plus count of $clog2(DEPTH)+1 bits; no overflow/underflow permitted.

Reset
REQ-018 SHALL on rst=1 clear count, pointers, fill flags and delay counter; data_addr_ok=0, data_data_ok=0, data_rdata=0, ram_en=0, ram_wen=0 during and first cycle after reset; requests outstanding at reset are discarded and never answered; pending SRAM read data arriving the cycle after reset is ignored.

Configuration
REQ-019 SHALL, with SRAM_LIKE_DELAY_EN defined, hold each filled head entry DELAY additional cycles (counter loaded on head becoming filled, data_ok when counter reaches 0); DELAY=0 equals macro-off timing.
REQ-020 SHALL, without SRAM_LIKE_DELAY_EN, contain no delay counter and meet REQ-014 exactly; DELAY ignored.

Structure
REQ-021 SHALL place size encodings (SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10) and size/offset-to-wen function in shared package sram_like_pkg.
REQ-022 SHALL implement the ordered response queue as sub-module sram_like_resp_fifo (DEPTH entries of {filled, wr, data[31:0]}).

Verification
REQ-023 Read: mem[0x100]=0xDEADBEEF, macro off, req rd addr 0x100 at T -> addr_ok at T, data_ok at T+1, rdata=0xDEADBEEF.
REQ-024 Writes: wr size0 addr 0x203 wdata 0xAA000000 -> ram_wen=4'b1000; size1 addr 0x202 -> 4'b1100; size2 addr 0x200 -> 4'b1111; each data_ok one cycle later, rdata=0.
REQ-025 Full: DEPTH=2, macro on DELAY=3, req held high -> two acceptances, addr_ok=0 third cycle; first data_ok at T+4; third request accepted only after a pop.
REQ-026 Ordering: 4 back-to-back reads 0x0,0x4,0x8,0xC (values 1,2,3,4), macro off -> data_ok on 4 consecutive cycles with rdata 1,2,3,4.
REQ-027 Reset mid-operation: accept 2 reads, assert rst next cycle for 1 cycle -> no data_ok ever for them; count=0, fresh read 0x100 answered normally with latency 1.
